srl_chain_checker: RTL and testbench
====================================

# srl_chain_checker

Self-checking, parametrised shift-register harness for SRL-mapping hardware tests. It drives CHANNELS independent DEPTH-bit shift chains from a shared LFSR and reads each chain through a dynamic tap address followed by a flop (mux-then-DFF). Each tap is compared every cycle against a structurally different ring-buffer reference model. Mismatches are reported as sticky per-channel error bits and a saturating count. It sits under a board `top`, with `error` routed to `led[7:0]` for the testbench assertion.

## Interface
- CHANNELS, 8: number of independent chains, 1..8.
- DEPTH, 32: bits per chain, a power of two, 16..128 (lets synthesis cascade SRL16/SRLC32 primitives).
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.
- AW, $clog2(DEPTH): tap address width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  shift enable for the LFSR, chains, reference and fill counter.
- addr  in  AW  tap select; 0 selects the most recent bit.
- error  out  CHANNELS  sticky mismatch flag per channel.
- err_count  out  16  saturating total of mismatches over all channels.
- ready  out  1  high once the checking window is open.
- tap  out  CHANNELS  registered tap outputs, for debug.

## Operation
- **LFSR:** 16-bit Fibonacci LFSR, taps 16,14,13,11. It advances only on cycles with ce=1.
- **Chain input:** channel c takes din[c] = lfsr[c].
- **Chains:** on ce, sr_c <= {sr_c[DEPTH-2:0], din[c]}. No reset is applied to the chain contents; this is required for SRL inference.
- **Tap:** every cycle, independent of ce, tap[c] <= sr_c[addr].
- **Reference:** a per-channel DEPTH-entry ring buffer with an AW-bit write pointer.
  - On ce, mem_c[wptr] <= din[c] and wptr increments, wrapping modulo DEPTH.
  - Every cycle, exp[c] <= mem_c[wptr-1-addr], computed modulo DEPTH. This is aligned with tap by construction.
- **Fill counter:** saturating counter, clamped at DEPTH, incremented on ce. valid = (fill == DEPTH). ready <= valid, registered so it aligns with tap and exp.
- **Check:** each cycle with ready=1 and tap[c] != exp[c]:
  - error[c] <= 1 (sticky until reset).
  - err_count increments by the popcount of the mismatches, saturating at 16'hFFFF.
- **Address changes:** addr may change on any cycle. Both paths sample the same addr in the same cycle, so no false error results.
- **Reset values:** error=0, err_count=0, ready=0, tap=0, exp=0, fill=0, wptr=0, lfsr=LFSR_SEED. The chain and mem contents are undefined until refilled.

## Timing
- The tap-to-flop latency is 1 cycle.
- A bit written at edge E appears on tap at edge E+addr+1 when ce is held high.
- An error flag rises 1 cycle after the mismatching tap/exp pair is registered.
- **First ready:** with ce held high from reset release, ready=1 after DEPTH+1 edges.
- **ce low:**
  - Chains, reference, LFSR and fill all hold.
  - tap and exp keep re-sampling and stay equal.
  - error is unaffected.
- **Reset:** asserting rst_n mid-run clears all outputs immediately (asynchronously), and ready stays 0 until DEPTH new shifts have occurred.
- **Saturation:** simultaneous mismatches on several channels in one cycle add their full count, saturating at 16'hFFFF.

## Configuration
- **SRL_CHAIN_INJECT_EN defined:**
  - An extra input port `inject` (1 bit) exists.
  - On a ce cycle with inject=1, channel 0's chain receives ~din[0]; the reference receives the true din[0].
  - With ce held high, error[0] rises at edge E0+addr+2 after the inject edge E0, provided ready=1.
  - The corrupted bit is shifted out after DEPTH shifts. After that, tap matches again but error[0] stays set.
- **Not defined:** the `inject` port is absent and chain inputs are never corrupted.

## Test plan
- **Fill and steady state:** reset 3 cycles, ce=1, addr=DEPTH-1, run 1000 cycles -> ready rises exactly DEPTH+1 edges after release; error=0 and err_count=0 throughout.
- **Address sweep:** addr steps 0..DEPTH-1, changing every 37 cycles, ce=1 -> error=0 and err_count=0; tap tracks the LFSR history.
- **ce gating:** ce random with 50% duty for 2000 cycles -> ready rises 1 edge after the DEPTH-th ce-high cycle; error=0.
- **Injection (SRL_CHAIN_INJECT_EN):**
  - Stimulus: addr=5, ready=1, a one-cycle inject pulse.
  - Response: error[0] rises 7 edges later; error[7:1]=0; err_count=1; only 1 count even if addr later changes.
- **Reset mid-run:** after an injected error, pulse rst_n low for 2 ns between edges -> error, err_count and ready read 0 immediately; ready returns after DEPTH+1 ce-high edges.
- **Minimum build:** CHANNELS=1, DEPTH=16, 500 cycles at addr=15 -> error=0; ready after 17 edges.

Source files
------------

// File: rtl/srl_chain_checker.sv
// Shift-register (SRL-mapped) chains checked every cycle against a ring-buffer reference model.
// Define SRL_CHAIN_INJECT_EN to add an `inject` port that corrupts channel 0's chain input.
module srl_chain_checker #(
    parameter int          CHANNELS  = 8,
    parameter int          DEPTH     = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          AW        = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
`ifdef SRL_CHAIN_INJECT_EN
    input  logic                inject,
`endif
    input  logic [AW-1:0]       addr,
    output logic [CHANNELS-1:0] error,
    output logic [15:0]         err_count,
    output logic                ready,
    output logic [CHANNELS-1:0] tap
);

    logic [15:0]                     lfsr_q;
    logic [AW-1:0]                   wptr_q;
    logic [AW:0]                     fill_q;
    logic [CHANNELS-1:0]             tap_q, exp_q, error_q;
    logic [15:0]                     err_count_q;
    logic                            ready_q;
    logic [CHANNELS-1:0][DEPTH-1:0]  mem_q;

    logic [CHANNELS-1:0] din, chain_in, tap_d, exp_d, mism;
    logic [AW-1:0]       rd_ptr;
    logic                valid;
    logic [3:0]          n_mism;
    logic [16:0]         cnt_sum;
    logic [15:0]         err_count_d;

    assign din = lfsr_q[CHANNELS-1:0];

`ifdef SRL_CHAIN_INJECT_EN
    always_comb begin
        chain_in    = din;
        chain_in[0] = din[0] ^ inject;
    end
`else
    assign chain_in = din;
`endif

    // Chains carry no reset so they can map onto SRL primitives.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chain
        logic [DEPTH-1:0] sr_q;
        always_ff @(posedge clk) begin
            if (ce) sr_q <= {sr_q[DEPTH-2:0], chain_in[c]};
        end
        assign tap_d[c] = sr_q[addr];
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            for (int c = 0; c < CHANNELS; c++) mem_q[c][wptr_q] <= din[c];
        end
    end

    assign rd_ptr = wptr_q - (AW)'(1) - addr;
    assign valid  = (fill_q == (AW+1)'(DEPTH));

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) exp_d[c] = mem_q[c][rd_ptr];
    end

    always_comb begin
        mism   = ready_q ? (tap_q ^ exp_q) : '0;
        n_mism = '0;
        for (int c = 0; c < CHANNELS; c++) n_mism = n_mism + 4'(mism[c]);
        cnt_sum     = {1'b0, err_count_q} + 17'(n_mism);
        err_count_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q      <= LFSR_SEED;
            wptr_q      <= '0;
            fill_q      <= '0;
            tap_q       <= '0;
            exp_q       <= '0;
            ready_q     <= 1'b0;
            error_q     <= '0;
            err_count_q <= '0;
        end else begin
            if (ce) begin
                lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                wptr_q <= wptr_q + (AW)'(1);
                if (!valid) fill_q <= fill_q + (AW+1)'(1);
            end
            tap_q       <= tap_d;
            exp_q       <= exp_d;
            ready_q     <= valid;
            error_q     <= error_q | mism;
            err_count_q <= err_count_d;
        end
    end

    assign error     = error_q;
    assign err_count = err_count_q;
    assign ready     = ready_q;
    assign tap       = tap_q;

endmodule

// File: tb/tb_srl_chain_checker.sv
// Bench for srl_chain_checker: history-queue model checked every negedge plus directed literal checks.
module tb_srl_chain_checker;
    localparam int NCH = 8;
    localparam int DEP = 32;
    localparam int AWT = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ce = 1'b0;
    logic            inject = 1'b0;
    logic [AWT-1:0]  addr = '1;
    logic [NCH-1:0]  error, tap;
    logic [15:0]     err_count;
    logic            ready;
    logic [0:0]      error2, tap2;
    logic [15:0]     err_count2;
    logic            ready2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    srl_chain_checker #(.CHANNELS(NCH), .DEPTH(DEP), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
`ifdef SRL_CHAIN_INJECT_EN
        .inject(inject),
`endif
        .addr(addr), .error(error), .err_count(err_count), .ready(ready), .tap(tap));

    srl_chain_checker #(.CHANNELS(1), .DEPTH(16), .LFSR_SEED(16'hACE1)) dut_min (
        .clk(clk), .rst_n(rst_n), .ce(1'b1),
`ifdef SRL_CHAIN_INJECT_EN
        .inject(1'b0),
`endif
        .addr(4'hF), .error(error2), .err_count(err_count2), .ready(ready2), .tap(tap2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Model: bit histories (newest first) for what the chain and the reference hold.
    bit             hk[NCH][$];
    bit             ht[NCH][$];
    bit             hm[$];
    logic [15:0]    m_lfsr = 16'hACE1, m_lfsr2 = 16'hACE1;
    int             m_fill = 0, m_fill2 = 0, m_cnt = 0;
    logic           m_ready = 0, m_ready2 = 0, m_tap2 = 0;
    logic [NCH-1:0] m_tap = '0, m_exp = '0, m_err = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr = 16'hACE1; m_lfsr2 = 16'hACE1;
            m_fill = 0; m_fill2 = 0; m_cnt = 0;
            m_ready = 0; m_ready2 = 0; m_tap2 = 0;
            m_tap = '0; m_exp = '0; m_err = '0;
            for (int c = 0; c < NCH; c++) begin hk[c].delete(); ht[c].delete(); end
            hm.delete();
        end else begin
            int n;
            n = 0;
            if (m_ready) begin
                for (int c = 0; c < NCH; c++)
                    if (m_tap[c] != m_exp[c]) begin m_err[c] = 1'b1; n++; end
                m_cnt = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
            end
            m_ready = (m_fill == DEP);
            for (int c = 0; c < NCH; c++) begin
                m_tap[c] = (hk[c].size() > int'(addr)) ? hk[c][addr] : 1'b0;
                m_exp[c] = (ht[c].size() > int'(addr)) ? ht[c][addr] : 1'b0;
            end
            if (ce) begin
                for (int c = 0; c < NCH; c++) begin
                    bit b;
                    b = m_lfsr[c];
                    ht[c].push_front(b);
`ifdef SRL_CHAIN_INJECT_EN
                    hk[c].push_front((c == 0 && inject) ? ~b : b);
`else
                    hk[c].push_front(b);
`endif
                    if (ht[c].size() > DEP) void'(ht[c].pop_back());
                    if (hk[c].size() > DEP) void'(hk[c].pop_back());
                end
                if (m_fill < DEP) m_fill++;
                m_lfsr = lfsr_next(m_lfsr);
            end
            // minimum build: ce tied high, addr fixed at 15
            m_ready2 = (m_fill2 == 16);
            m_tap2   = (hm.size() > 15) ? hm[15] : 1'b0;
            hm.push_front(m_lfsr2[0]);
            if (hm.size() > 16) void'(hm.pop_back());
            if (m_fill2 < 16) m_fill2++;
            m_lfsr2 = lfsr_next(m_lfsr2);
        end
    end

    always @(negedge clk) begin
        chk("ready", ready, m_ready);
        chk("error", error, m_err);
        chk("err_count", err_count, m_cnt);
        if (m_ready) chk("tap", tap, m_tap);
        chk("min_ready", ready2, m_ready2);
        chk("min_error", error2, 0);
        chk("min_err_count", err_count2, 0);
        if (m_ready2) chk("min_tap", tap2, m_tap2);
    end

    // Counts edges from now until main ready rises; returns 0 on timeout.
    task automatic edges_to_ready(output int n, output int n2);
        n = 0; n2 = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (ready2 && n2 == 0) n2 = i;
            if (ready) begin n = i; break; end
        end
    endtask

    initial begin
        int n, n2, k, e_full, first;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_error", error, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_tap", tap, 0);

        // fill and steady state
        rst_n = 1'b1; ce = 1'b1; addr = AWT'(DEP - 1);
        @(posedge clk); #1;
        chk("model_lfsr_step1", m_lfsr, 16'h59C3);
        edges_to_ready(n, n2);
        chk("first_ready_edge", n + 1, DEP + 1);
        chk("min_ready_edge", n2 + 1, 17);
        repeat (1000) @(negedge clk);
        chk("steady_err_count", err_count, 0);

        // address sweep
        for (int a = 0; a < DEP; a++) begin
            @(negedge clk); addr = AWT'(a);
            repeat (36) @(negedge clk);
        end
        chk("sweep_error", error, 0);

        // ce gating from a fresh reset
        @(posedge clk); #2 rst_n = 1'b0; #2 rst_n = 1'b1;
        k = 0; e_full = 0; first = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            ce = 1'($urandom_range(0, 1));
            if (i % 97 == 0) addr = AWT'($urandom_range(0, DEP - 1));
            @(posedge clk); #1;
            if (ce) begin k++; if (k == DEP) e_full = i; end
            if (ready && first == 0) first = i;
        end
        chk("ce_gate_ready_gap", first - e_full, 1);
        chk("ce_gate_error", error, 0);

`ifdef SRL_CHAIN_INJECT_EN
        @(negedge clk); ce = 1'b1; addr = 5'd5;
        repeat (40) @(negedge clk);
        chk("inj_pre_ready", ready, 1);
        inject = 1'b1;
        @(negedge clk); inject = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (error[0]) begin n = i; break; end
        end
        chk("inj_error_edge", n, 7);
        chk("inj_error_hi", error[NCH-1:1], 0);
        chk("inj_err_count", err_count, 1);
        repeat (40) @(negedge clk);
        addr = 5'd17;
        repeat (40) @(negedge clk);
        chk("inj_count_after_addr", err_count, 1);
        chk("inj_sticky", error, 8'h01);
`endif

        // reset mid-run
        @(negedge clk); ce = 1'b1;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("midrst_error", error, 0);
        chk("midrst_err_count", err_count, 0);
        chk("midrst_ready", ready, 0);
        #1 rst_n = 1'b1;
        edges_to_ready(n, n2);
        chk("midrst_ready_edge", n, DEP + 1);
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
